// File: rtl/ddr_ctrl_pkg.sv
// Shared DDR controller types and default timing constants.
// Used by the refresh scheduler and the command arbiter.
package ddr_ctrl_pkg;

  typedef enum logic [1:0] {
    REF_IDLE = 2'd0,
    REF_REQ  = 2'd1,
    REF_TRFC = 2'd2
  } ref_state_e;

  localparam int DDR_TREFI_C        = 780;
  localparam int DDR_TRFC_C         = 11;
  localparam int DDR_MAX_POSTPONE_C = 8;

endpackage

// File: rtl/ddr_refresh_scheduler_timer.sv
// Free-running tREFI interval timer; tick_o marks the last cycle.
// Ports: clk_i, reset_ni (async low), en_i, tick_o.
module refresh_interval_timer #(
  parameter int TREFI_P = 780,
  parameter int WIDTH   = $clog2(TREFI_P)
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [WIDTH-1:0] LAST_C = WIDTH'(TREFI_P - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == LAST_C);
  assign tick_o = en_i & w_last;

  // Disabling parks the count at 0 so a re-enable
  // always starts a full interval.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count <= '0;
    end else if (!en_i) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ddr_refresh_scheduler.sv
// DRAM refresh scheduler: accrues owed refreshes per tREFI, defers
// them during bursts, and offers them to the arbiter (valid/ready).
// Ports: clk_i, reset_ni, en_i, busy_i, ref_ready_i in;
//   ref_valid_o, urgent_o, trfc_busy_o, pending_o, overflow_o out.
module ddr_refresh_scheduler
  import ddr_ctrl_pkg::*;
#(
  parameter int TREFI_P        = DDR_TREFI_C,
  parameter int TRFC_P         = DDR_TRFC_C,
  parameter int MAX_POSTPONE_P = DDR_MAX_POSTPONE_C,
  localparam int PEND_W_P      = $clog2(MAX_POSTPONE_P + 1)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                en_i,
  input  logic                busy_i,
  input  logic                ref_ready_i,
  output logic                ref_valid_o,
  output logic                urgent_o,
  output logic                trfc_busy_o,
  output logic [PEND_W_P-1:0] pending_o,
  output logic                overflow_o
);

  localparam int TRFC_W =
    (TRFC_P > 1) ? $clog2(TRFC_P) : 1;
  localparam logic [TRFC_W-1:0] TRFC_LAST_C =
    TRFC_W'(TRFC_P - 1);
  localparam logic [PEND_W_P-1:0] PEND_MAX_C =
    PEND_W_P'(MAX_POSTPONE_P);

  ref_state_e          r_state;
  ref_state_e          w_state_nxt;
  logic [PEND_W_P-1:0] r_pending;
  logic [PEND_W_P-1:0] w_pend_nxt;
  logic [TRFC_W-1:0]   r_trfc_cnt;
  logic [TRFC_W-1:0]   w_trfc_nxt;
  logic                r_overflow;
  logic                w_ovf_set;
  logic                w_tick;
  logic                w_hs;
  logic                w_sat;

  refresh_interval_timer #(
    .TREFI_P (TREFI_P)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (en_i),
    .tick_o   (w_tick)
  );

  assign w_sat = (r_pending == PEND_MAX_C);
  assign w_hs  = (r_state == REF_REQ) & ref_ready_i;

  // A tick and a handshake in one cycle cancel out.
  // A tick into a full counter is lost and flagged.
  always_comb begin
    w_pend_nxt = r_pending;
    w_ovf_set  = 1'b0;
    case ({w_tick, w_hs})
      2'b10: begin
        if (w_sat) begin
          w_ovf_set = 1'b1;
        end else begin
          w_pend_nxt = r_pending + 1'b1;
        end
      end
      2'b01: w_pend_nxt = r_pending - 1'b1;
      default: w_pend_nxt = r_pending;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_trfc_nxt  = r_trfc_cnt;
    unique case (r_state)
      REF_IDLE: begin
        if ((r_pending != '0) && (!busy_i || w_sat)) begin
          w_state_nxt = REF_REQ;
        end
      end
      REF_REQ: begin
        // Offer stays up until taken; busy/en are ignored.
        if (ref_ready_i) begin
          w_state_nxt = REF_TRFC;
          w_trfc_nxt  = TRFC_LAST_C;
        end
      end
      REF_TRFC: begin
        if (r_trfc_cnt == '0) begin
          w_state_nxt = REF_IDLE;
        end else begin
          w_trfc_nxt = r_trfc_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = REF_IDLE;
        w_trfc_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= REF_IDLE;
      r_pending  <= '0;
      r_trfc_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pend_nxt;
      r_trfc_cnt <= w_trfc_nxt;
      r_overflow <= r_overflow | w_ovf_set;
    end
  end

  assign ref_valid_o = (r_state == REF_REQ);
  assign trfc_busy_o = (r_state == REF_TRFC);
  assign urgent_o    = w_sat;
  assign pending_o   = r_pending;
  assign overflow_o  = r_overflow;

endmodule
